// File: rtl/ov7670_frame_ctrl.sv
// OV7670 frame capture controller.
// Arms on a snapshot request and gates the capture datapath for whole
// frames only, always starting at a vsync falling edge. It can capture a
// single frame or every frame, and counts completed frames.
// Optional geometry checking (lines per frame, bytes per line) is compiled
// in when the macro OV7670_FRAME_CHECK_EN is defined; otherwise frame_err
// is tied low.
module ov7670_frame_ctrl #(
  parameter int LINES  = 240,
  parameter int PIXELS = 320
) (
  input  logic       pclk_12,
  input  logic       reset_n,
  input  logic       config_done,
  input  logic       snap_req,
  input  logic       continuous,
  input  logic       vsync,
  input  logic       href,
  output logic       capture_en,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       vsync_q;
  logic       href_q;
  logic       capture_en_q;
  logic [7:0] count_q;

  logic vsync_fall;
  logic vsync_rise;
  logic href_fall;

  assign vsync_fall = vsync_q & ~vsync;
  assign vsync_rise = ~vsync_q & vsync;
  assign href_fall  = href_q & ~href;

  // Next-state logic; losing sensor configuration always forces IDLE.
  always_comb begin
    state_d = state_q;
    if (!config_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (snap_req)   state_d = ARM;
        ARM:     if (vsync_fall) state_d = CAPTURE;
        CAPTURE: if (vsync_rise) state_d = DONE;
        DONE:    state_d = continuous ? ARM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, sync-edge history, capture gate and completed-frame counter.
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b1;
      href_q       <= 1'b0;
      capture_en_q <= 1'b0;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      href_q       <= href;
      capture_en_q <= (state_d == CAPTURE);
      if (state_d == DONE) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign capture_en  = capture_en_q;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign frame_count = count_q;

`ifdef OV7670_FRAME_CHECK_EN
  logic [9:0] byte_q;
  logic [8:0] line_q;
  logic       sticky_q;
  logic       frame_err_q;
  logic       enter_capture;

  assign enter_capture = (state_d == CAPTURE) && (state_q != CAPTURE);

  // Per-frame geometry counters; the error flag is latched as DONE is entered
  // so it is valid alongside frame_done and held until the next frame ends.
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      byte_q      <= 10'd0;
      line_q      <= 9'd0;
      sticky_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (enter_capture) begin
        byte_q   <= 10'd0;
        line_q   <= 9'd0;
        sticky_q <= 1'b0;
      end else if (state_q == CAPTURE) begin
        if (href_fall) begin
          byte_q <= 10'd0;
          if (line_q != 9'd511) begin
            line_q <= line_q + 9'd1;
          end
          if (byte_q != 10'(PIXELS)) begin
            sticky_q <= 1'b1;
          end
        end else if (href && (byte_q != 10'd1023)) begin
          byte_q <= byte_q + 10'd1;
        end
      end
      if (state_d == DONE) begin
        frame_err_q <= sticky_q | (line_q != 9'(LINES));
      end
    end
  end

  assign frame_err = frame_err_q;
`else
  logic unused_geometry;

  assign unused_geometry = ^{href_fall, (LINES != 0), (PIXELS != 0)};
  assign frame_err       = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_frame_ctrl.sv
// Directed self-checking bench for ov7670_frame_ctrl using a reduced frame
// geometry so that long multi-frame sequences stay short.
module tb_ov7670_frame_ctrl;

  localparam int L = 3;
  localparam int P = 5;
  // capture_en samples per full frame: 2 leading + L lines of (P + 2)
  localparam int CAP_FULL = 2 + L * (P + 2);

  logic       pclk_12;
  logic       reset_n;
  logic       config_done;
  logic       snap_req;
  logic       continuous;
  logic       vsync;
  logic       href;
  logic       capture_en;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [7:0] frame_count;

  int checkCount;
  int passCount;
  int doneSeen;
  int capSeen;
  logic expErrBad;

  ov7670_frame_ctrl #(.LINES(L), .PIXELS(P)) dut (
    .pclk_12     (pclk_12),
    .reset_n     (reset_n),
    .config_done (config_done),
    .snap_req    (snap_req),
    .continuous  (continuous),
    .vsync       (vsync),
    .href        (href),
    .capture_en  (capture_en),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .frame_count (frame_count)
  );

  // 12 MHz-ish pixel clock, period abstracted to 10 time units
  initial pclk_12 = 1'b0;
  always #5 pclk_12 = ~pclk_12;

  // Drive sync inputs, advance one clock, then sample outputs 1 unit later
  task automatic applyStimulus(input logic v, input logic h);
    vsync = v;
    href  = h;
    @(posedge pclk_12);
    #1;
    if (frame_done === 1'b1) doneSeen++;
    if (capture_en === 1'b1) capSeen++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  // One frame: vsync low, lines of href, vsync high for three cycles.
  // shortLine selects a line carrying P-1 bytes; dropLine clears continuous.
  task automatic sendFrame(input int lines, input int shortLine, input int dropLine);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    for (int l = 0; l < lines; l++) begin
      if (l == dropLine) continuous = 1'b0;
      for (int b = 0; b < ((l == shortLine) ? P - 1 : P); b++) applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
  endtask

  task automatic pulseSnap();
    snap_req = 1'b1;
    applyStimulus(1'b1, 1'b0);
    snap_req = 1'b0;
  endtask

  initial begin
    checkCount  = 0;
    passCount   = 0;
    doneSeen    = 0;
    capSeen     = 0;
`ifdef OV7670_FRAME_CHECK_EN
    expErrBad   = 1'b1;
`else
    expErrBad   = 1'b0;
`endif
    reset_n     = 1'b0;
    config_done = 1'b0;
    snap_req    = 1'b0;
    continuous  = 1'b0;
    vsync       = 1'b1;
    href        = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_capture_en", capture_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_frame_count", frame_count, 0);
    @(negedge pclk_12);
    reset_n     = 1'b1;
    config_done = 1'b1;
    applyStimulus(1'b1, 1'b0);

    // Single snap, one full frame
    $display("[TB] single snap");
    pulseSnap();
    checkOutput("snap_busy", busy, 1);
    checkOutput("snap_cap_before", capture_en, 0);
    doneSeen = 0; capSeen = 0;
    sendFrame(L, -1, -1);
    checkOutput("single_cap_cycles", capSeen, CAP_FULL);
    checkOutput("single_done", doneSeen, 1);
    checkOutput("single_count", frame_count, 1);
    checkOutput("single_err", frame_err, 0);
    checkOutput("single_idle", busy, 0);

    // Snap arriving mid-frame waits for the next frame boundary
    $display("[TB] mid-frame snap");
    doneSeen = 0; capSeen = 0;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    snap_req = 1'b1;
    applyStimulus(1'b0, 1'b1);
    snap_req = 1'b0;
    applyStimulus(1'b0, 1'b0);
    snap_req = 1'b1;
    applyStimulus(1'b0, 1'b0);
    snap_req = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("mid_armed", busy, 1);
    checkOutput("mid_no_cap", capSeen, 0);
    sendFrame(L, -1, -1);
    checkOutput("mid_cap_cycles", capSeen, CAP_FULL);
    checkOutput("mid_done", doneSeen, 1);
    checkOutput("mid_count", frame_count, 2);

    // Continuous capture of three frames, dropped during the third
    $display("[TB] continuous");
    continuous = 1'b1;
    doneSeen = 0; capSeen = 0;
    pulseSnap();
    sendFrame(L, -1, -1);
    sendFrame(L, -1, -1);
    checkOutput("cont_still_busy", busy, 1);
    sendFrame(L, -1, 1);
    checkOutput("cont_done", doneSeen, 3);
    checkOutput("cont_cap_cycles", capSeen, 3 * CAP_FULL);
    checkOutput("cont_count", frame_count, 5);
    checkOutput("cont_idle", busy, 0);

    // Geometry checks: missing line, short line, clean frame
    $display("[TB] geometry");
    pulseSnap();
    sendFrame(L - 1, -1, -1);
    checkOutput("geom_lines_err", frame_err, 32'(expErrBad));
    applyStimulus(1'b1, 1'b0);
    checkOutput("geom_err_held", frame_err, 32'(expErrBad));
    pulseSnap();
    sendFrame(L, 1, -1);
    checkOutput("geom_bytes_err", frame_err, 32'(expErrBad));
    pulseSnap();
    sendFrame(L, -1, -1);
    checkOutput("geom_clean_err", frame_err, 0);
    checkOutput("geom_count", frame_count, 8);

    // Abort by dropping config_done mid-capture
    $display("[TB] config abort");
    doneSeen = 0;
    pulseSnap();
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_cap_rise", capture_en, 1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    config_done = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("abort_cap", capture_en, 0);
    checkOutput("abort_busy", busy, 0);
    config_done = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_count", frame_count, 8);
    checkOutput("abort_idle", busy, 0);

    // Asynchronous reset mid-frame
    $display("[TB] reset abort");
    pulseSnap();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("arst_cap", capture_en, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_count", frame_count, 0);
    checkOutput("arst_done", frame_done, 0);
    checkOutput("arst_err", frame_err, 0);
    reset_n = 1'b1;
    doneSeen = 0; capSeen = 0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    sendFrame(L, -1, -1);
    checkOutput("arst_wait_cap", capSeen, 0);
    checkOutput("arst_wait_done", doneSeen, 0);
    checkOutput("arst_wait_idle", busy, 0);

    // 256 continuous frames wrap the counter
    $display("[TB] wrap");
    continuous = 1'b1;
    doneSeen = 0;
    pulseSnap();
    for (int f = 0; f < 255; f++) sendFrame(L, -1, -1);
    checkOutput("wrap_255", frame_count, 255);
    sendFrame(L, -1, 0);
    checkOutput("wrap_zero", frame_count, 0);
    checkOutput("wrap_done", doneSeen, 256);
    checkOutput("wrap_idle", busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
